// File: rtl/flash_lock_verify_pkg.sv
// Shared flash SPI constants, status-register packing and state encodings
// used by the lock writer / lock verifier pair.
`default_nettype none

package flash_lock_verify_pkg;

    localparam logic [7:0] FLASH_CMD_RDSR1 = 8'h05;
    localparam logic [7:0] FLASH_CMD_RDSR2 = 8'h35;
    localparam logic [7:0] FLASH_CMD_WREN  = 8'h06;
    localparam logic [7:0] FLASH_CMD_WRSR  = 8'h01;

    localparam int SR_WORD_BITS = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        GAP      = 3'd4,
        DONE     = 3'd5
    } verify_state_e;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_SETUP = 2'd1,
        F_SHIFT = 2'd2,
        F_HOLD  = 2'd3
    } frame_state_e;

    // Status word layout shared with the lock writer: SR2 in the upper byte.
    function automatic logic [SR_WORD_BITS-1:0] pack_sr(input logic [7:0] sr2,
                                                        input logic [7:0] sr1);
        return {sr2, sr1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/flash_lock_verify_spi_frame16.sv
// One chip-select framed SPI mode-0 exchange: 8 opcode bits out, 8 response
// bits in, MSB first, with SCK half-period of clk_div+1 clk cycles.
`default_nettype none

module flash_lock_verify_spi_frame16
    import flash_lock_verify_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic [3:0] clk_div,
    input  logic       spi_miso,
    output logic [7:0] rx_byte,
    output logic       setup_end,
    output logic       shift_end,
    output logic       done,
    output logic       spi_clk,
    output logic       spi_mosi,
    output logic       spi_cs_n
);

    frame_state_e state;
    frame_state_e state_nx;

    logic [3:0] div_cnt;
    logic [4:0] half_cnt;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic       tick;

    assign tick      = (div_cnt == clk_div);
    assign setup_end = (state == F_SETUP) && tick;
    assign shift_end = (state == F_SHIFT) && tick && (half_cnt == 5'd31);
    assign done      = (state == F_HOLD) && tick;
    assign rx_byte   = rx_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= F_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            F_IDLE:  if (start)     state_nx = F_SETUP;
            F_SETUP: if (tick)      state_nx = F_SHIFT;
            F_SHIFT: if (shift_end) state_nx = F_HOLD;
            F_HOLD:  if (tick)      state_nx = F_IDLE;
            default:                state_nx = F_IDLE;
        endcase
    end

    // Even half-periods are SCK high, odd are low; response bits arrive on
    // rises 8..15 (zero-based), i.e. at the ends of odd halves 15..29.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= 4'd0;
            half_cnt <= 5'd0;
            tx_sr    <= 8'd0;
            rx_sr    <= 8'd0;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b1;
        end else begin
            case (state)
                F_IDLE: begin
                    if (start) begin
                        spi_cs_n <= 1'b0;
                        spi_mosi <= tx_byte[7];
                        tx_sr    <= {tx_byte[6:0], 1'b0};
                        div_cnt  <= 4'd0;
                    end
                end
                F_SETUP: begin
                    if (tick) begin
                        div_cnt  <= 4'd0;
                        half_cnt <= 5'd0;
                        spi_clk  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end
                F_SHIFT: begin
                    if (tick) begin
                        div_cnt <= 4'd0;
                        if (half_cnt != 5'd31) begin
                            half_cnt <= half_cnt + 5'd1;
                            if (!half_cnt[0]) begin
                                spi_clk  <= 1'b0;
                                spi_mosi <= tx_sr[7];
                                tx_sr    <= {tx_sr[6:0], 1'b0};
                            end else begin
                                spi_clk <= 1'b1;
                                if (half_cnt >= 5'd15) begin
                                    rx_sr <= {rx_sr[6:0], spi_miso};
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end
                F_HOLD: begin
                    if (tick) begin
                        div_cnt  <= 4'd0;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end
                default: begin
                    div_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/flash_lock_verify.sv
// Reads flash SR1 then SR2 over SPI and compares {SR2,SR1} against the
// expected lock configuration under a bit mask.
`default_nettype none

module flash_lock_verify
    import flash_lock_verify_pkg::*;
#(
    parameter logic [15:0] LOCK_DATA  = 16'h0000,
    parameter logic [15:0] LOCK_MASK  = 16'hFFFF,
    parameter int          CLK_DIV    = 0,
    parameter int          GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    output logic        rdy,
    output logic        busy,
    output logic        match,
    output logic [15:0] sr_data,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_clk,
    output logic        spi_cs_n
);

    localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]      DIV      = 4'(CLK_DIV);

    verify_state_e state;
    verify_state_e state_nx;

    logic             accept;
    logic             second;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       sr1_q;
    logic             gap_end;
    logic             idle_like;

    logic             start_frame;
    logic [7:0]       tx_byte;
    logic [7:0]       rx_byte;
    logic             setup_end;
    logic             shift_end;
    logic             frame_done;
    logic [15:0]      sr_word;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);
    assign tx_byte   = (state == GAP) ? FLASH_CMD_RDSR2 : FLASH_CMD_RDSR1;
    assign sr_word   = pack_sr(rx_byte, sr1_q);

    flash_lock_verify_spi_frame16 u_frame (
        .clk       (clk),
        .rst       (rst),
        .start     (start_frame),
        .tx_byte   (tx_byte),
        .clk_div   (DIV),
        .spi_miso  (spi_miso),
        .rx_byte   (rx_byte),
        .setup_end (setup_end),
        .shift_end (shift_end),
        .done      (frame_done),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        busy        = 1'b1;
        rdy         = 1'b0;
        start_frame = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nx    = CS_SETUP;
                    start_frame = 1'b1;
                end
            end
            DONE: begin
                busy = 1'b0;
                rdy  = 1'b1;
                if (accept) begin
                    state_nx    = CS_SETUP;
                    start_frame = 1'b1;
                end
            end
            CS_SETUP: if (setup_end) state_nx = SHIFT;
            SHIFT:    if (shift_end) state_nx = CS_HOLD;
            CS_HOLD:  if (frame_done) state_nx = second ? DONE : GAP;
            GAP: begin
                if (gap_end) begin
                    state_nx    = CS_SETUP;
                    start_frame = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // go is only registered while idle, so a request landing on the edge
    // that completes a run (state still CS_HOLD) is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accept  <= 1'b0;
            second  <= 1'b0;
            gap_cnt <= '0;
            sr1_q   <= 8'd0;
            sr_data <= 16'd0;
            match   <= 1'b0;
        end else begin
            accept <= go && idle_like;
            if (idle_like && accept) begin
                match  <= 1'b0;
                second <= 1'b0;
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
            if (gap_end) begin
                second <= 1'b1;
            end
            if ((state == CS_HOLD) && frame_done) begin
                if (second) begin
                    sr_data <= sr_word;
                    match   <= (((sr_word ^ LOCK_DATA) & LOCK_MASK) == 16'h0000);
                end else begin
                    sr1_q <= rx_byte;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_flash_lock_verify.sv
// Bench for flash_lock_verify: two instances (default timing, and
// CLK_DIV=3/GAP=1 with a low-byte mask) against a clock-sampled flash model.
`default_nettype none

module tb_flash_lock_verify;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  go = 2'b00;
    logic [1:0]  miso = 2'b00;
    wire  [1:0]  rdy, busy, match, sck, mosi, cs_n;
    wire  [15:0] sr_d0, sr_d1;

    always #5 clk = ~clk;

    flash_lock_verify #(.LOCK_DATA(16'h029C), .LOCK_MASK(16'hFFFF),
                        .CLK_DIV(0), .GAP_CYCLES(8)) dut0 (
        .clk(clk), .rst(rst), .go(go[0]), .rdy(rdy[0]), .busy(busy[0]),
        .match(match[0]), .sr_data(sr_d0), .spi_mosi(mosi[0]),
        .spi_miso(miso[0]), .spi_clk(sck[0]), .spi_cs_n(cs_n[0]));

    flash_lock_verify #(.LOCK_DATA(16'h029C), .LOCK_MASK(16'h00FF),
                        .CLK_DIV(3), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .go(go[1]), .rdy(rdy[1]), .busy(busy[1]),
        .match(match[1]), .sr_data(sr_d1), .spi_mosi(mosi[1]),
        .spi_miso(miso[1]), .spi_clk(sck[1]), .spi_cs_n(cs_n[1]));

    function automatic int hp(input int i);
        return (i == 0) ? 1 : 4;
    endfunction
    function automatic int gapc(input int i);
        return (i == 0) ? 8 : 1;
    endfunction
    function automatic int lat_exp(input int i);
        return 1 + 68 * hp(i) + gapc(i);
    endfunction
    function automatic logic [15:0] mask_of(input int i);
        return (i == 0) ? 16'hFFFF : 16'h00FF;
    endfunction
    function automatic int sr_of(input int i);
        return (i == 0) ? int'(sr_d0) : int'(sr_d1);
    endfunction

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- flash model (sampled on the falling clk edge) -------
    typedef struct {
        int inst;
        int cmd;
        int rises;
        int gap;
    } frame_t;
    frame_t flog[$];

    logic [7:0] sr1_val = 8'h00;
    logic [7:0] sr2_val = 8'h00;
    logic [7:0] resp;
    int rises [2] = '{0, 0};
    int cmd [2] = '{0, 0};
    int lvl_len [2] = '{0, 0};
    int gap_len [2] = '{0, 0};
    int cur_gap [2] = '{0, 0};
    logic [1:0] prev_cs = 2'b11;
    logic [1:0] prev_sck = 2'b00;
    int idle_err = 0, phase_err = 0, mosi_err = 0, ovl_err = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rdy[i] && busy[i]) ovl_err++;
            if (cs_n[i]) begin
                if (sck[i]) idle_err++;
                if (!prev_cs[i] && !rst) begin
                    if (lvl_len[i] != 2 * hp(i)) phase_err++;
                    flog.push_back('{i, cmd[i], rises[i], cur_gap[i]});
                end
                gap_len[i]++;
            end else if (prev_cs[i]) begin
                rises[i]   = 0;
                cmd[i]     = 0;
                lvl_len[i] = 1;
                cur_gap[i] = gap_len[i];
                gap_len[i] = 0;
            end else if (sck[i] != prev_sck[i]) begin
                if (!rst && lvl_len[i] != hp(i)) phase_err++;
                lvl_len[i] = 1;
                if (sck[i]) begin
                    if (rises[i] < 8) cmd[i] = ((cmd[i] << 1) | (mosi[i] ? 1 : 0)) & 255;
                    else if (mosi[i]) mosi_err++;
                    rises[i]++;
                end else if (rises[i] >= 8 && rises[i] < 16) begin
                    resp = (cmd[i] == 8'h05) ? sr1_val : (cmd[i] == 8'h35) ? sr2_val : 8'hA5;
                    miso[i] = resp[15 - rises[i]];
                end
            end else begin
                lvl_len[i]++;
            end
        end
        prev_cs  = cs_n;
        prev_sck = sck;
    end

    // ---------------- helpers ----------------------------------------------
    task automatic check_frames(input int id);
        chk("frame_count", flog.size(), 2);
        if (flog.size() == 2) begin
            chk("frame_inst", flog[0].inst, id);
            chk("frame0_cmd", flog[0].cmd, 8'h05);
            chk("frame0_rises", flog[0].rises, 16);
            chk("frame1_cmd", flog[1].cmd, 8'h35);
            chk("frame1_rises", flog[1].rises, 16);
            chk("gap_len", flog[1].gap, gapc(id));
        end
    endtask

    task automatic run(input int id, output int lat);
        int n;
        flog.delete();
        @(posedge clk); #1; go[id] = 1'b1;
        @(posedge clk); #1; go[id] = 1'b0;
        n = 0;
        lat = -1;
        while (n < 1000 && lat < 0) begin
            @(posedge clk); n++; #1;
            if (rdy[id]) lat = n;
        end
        @(negedge clk); #1;
        check_frames(id);
    endtask

    typedef struct {
        logic [7:0]  sr1;
        logic [7:0]  sr2;
        logic [15:0] exp_sr;
        logic        exp_m0;
        logic        exp_m1;
    } vec_t;
    vec_t vecs [6];

    initial begin
        int lat, lat2, n, r81, id;
        logic [7:0] a, b;
        logic [15:0] exp_w;

        vecs[0] = '{8'h9C, 8'h02, 16'h029C, 1'b1, 1'b1};
        vecs[1] = '{8'h9C, 8'h00, 16'h009C, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 8'h02, 16'h0200, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 16'hFFFF, 1'b0, 1'b0};
        vecs[4] = '{8'h9C, 8'hFF, 16'hFF9C, 1'b0, 1'b1};
        vecs[5] = '{8'h1C, 8'h02, 16'h021C, 1'b0, 1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", rdy[0], 0);
        chk("reset_busy", busy[0], 0);
        chk("reset_match", match[0], 0);
        chk("reset_sr_data", sr_d0, 0);
        chk("reset_cs_n", cs_n[0], 1);
        chk("reset_sck", sck[0], 0);
        chk("reset_mosi", mosi[0], 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            sr1_val = vecs[v].sr1;
            sr2_val = vecs[v].sr2;
            run(0, lat);
            chk("vec_lat0", lat, 77);
            chk("vec_sr0", sr_d0, vecs[v].exp_sr);
            chk("vec_match0", match[0], vecs[v].exp_m0);
            run(1, lat);
            chk("vec_lat1", lat, 274);
            chk("vec_sr1", sr_d1, vecs[v].exp_sr);
            chk("vec_match1", match[1], vecs[v].exp_m1);
        end

        // go re-pulsed mid-run is ignored; go at edge 80 restarts
        sr1_val = 8'h9C;
        sr2_val = 8'h02;
        @(posedge clk); #1; go[0] = 1'b1;
        @(posedge clk); #1; go[0] = 1'b0;
        n = 0; lat = -1; lat2 = -1; r81 = -1;
        while (n < 400 && lat2 < 0) begin
            @(posedge clk); n++; #1;
            go[0] = (n == 9 || n == 39 || n == 79);
            if (n == 1) chk("busy_after_accept", busy[0], 1);
            if (n == 1) chk("rdy_cleared", rdy[0], 0);
            if (rdy[0] && lat < 0) lat = n;
            if (n == 81) r81 = rdy[0];
            if (n > 81 && rdy[0] && lat2 < 0) lat2 = n;
        end
        go[0] = 1'b0;
        chk("repulse_lat", lat, 77);
        chk("restart_rdy_low", r81, 0);
        chk("restart_lat", lat2, 157);

        // go on the edge where rdy rises is dropped
        @(posedge clk); #1; go[0] = 1'b1;
        @(posedge clk); #1; go[0] = 1'b0;
        n = 0;
        while (n < 80) begin
            @(posedge clk); n++; #1;
            go[0] = (n == 76);
            if (n == 77) chk("rdy_edge_rdy", rdy[0], 1);
            if (n == 79) chk("rdy_edge_ignored_rdy", rdy[0], 1);
            if (n == 79) chk("rdy_edge_ignored_busy", busy[0], 0);
        end
        go[0] = 1'b0;

        // asynchronous reset during frame-0 shifting
        @(posedge clk); #1; go[0] = 1'b1;
        @(posedge clk); #1; go[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("pre_rst_cs_n", cs_n[0], 0);
        rst = 1'b1;
        #1;
        chk("async_rst_cs_n", cs_n[0], 1);
        chk("async_rst_sck", sck[0], 0);
        chk("async_rst_busy", busy[0], 0);
        chk("async_rst_rdy", rdy[0], 0);
        chk("async_rst_mosi", mosi[0], 0);
        chk("async_rst_sr", sr_d0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(0, lat);
        chk("post_rst_lat", lat, 77);
        chk("post_rst_sr", sr_d0, 16'h029C);
        chk("post_rst_match", match[0], 1);

        // randomized status values against the masked-compare rule
        for (int k = 0; k < 8; k++) begin
            id = k % 2;
            a = ($urandom_range(0, 2) == 0) ? 8'h9C : 8'($urandom);
            b = ($urandom_range(0, 2) == 0) ? 8'h02 : 8'($urandom);
            sr1_val = a;
            sr2_val = b;
            repeat ($urandom_range(0, 5)) @(posedge clk);
            run(id, lat);
            exp_w = {b, a};
            chk("rand_lat", lat, lat_exp(id));
            chk("rand_sr", sr_of(id), exp_w);
            chk("rand_match", match[id], (((exp_w ^ 16'h029C) & mask_of(id)) == 16'h0) ? 1 : 0);
        end

        chk("sck_idle_low", idle_err, 0);
        chk("sck_phase_len", phase_err, 0);
        chk("mosi_zero_resp", mosi_err, 0);
        chk("rdy_busy_overlap", ovl_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
